// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_buffer
//  Purpose  : Captures a sample stream into a circular RAM around a trigger.
//             The pre/post split is set by a delay fraction. The captured
//             window is then drained oldest-first over a ready/valid channel.
//             Stream mode runs the same RAM as a FIFO with a sticky
//             overflow flag.
//  Ports    : CLK_I, RST_NI (async, active-low)
//             CONTROL_*  - mode/delay write channel (ready in IDLE/STREAM)
//             SAMPLE_*   - trace samples and trigger, no backpressure
//             DATA_*     - registered readout stream
//             STATUS_*   - {[ts], overflow, triggered, fill, trig_ptr}
//  Config   : define TRB_TRIG_TIMESTAMP_EN to add a 32-bit trigger timestamp
//             in the MSBs of STATUS_O
//  Revision : 1.0 - initial release
// ============================================================================
module trace_capture_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int DELAY_BITS = 3,
  localparam int AW        = $clog2(DEPTH),
`ifdef TRB_TRIG_TIMESTAMP_EN
  localparam int SW        = 2*AW + 3 + 32
`else
  localparam int SW        = 2*AW + 3
`endif
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  CONTROL_VALID_I,
  output logic                  CONTROL_READY_O,
  input  logic                  CONTROL_MODE_I,
  input  logic [DELAY_BITS-1:0] CONTROL_DELAY_I,
  input  logic                  SAMPLE_VALID_I,
  input  logic [DATA_WIDTH-1:0] SAMPLE_I,
  input  logic                  TRIG_I,
  output logic                  DATA_VALID_O,
  input  logic                  DATA_READY_I,
  output logic [DATA_WIDTH-1:0] DATA_O,
  output logic                  STATUS_VALID_O,
  input  logic                  STATUS_READY_I,
  output logic [SW-1:0]         STATUS_O
);

  localparam int PW = AW + DELAY_BITS + 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_POST    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_READOUT = 3'd4;
  localparam logic [2:0] S_STREAM  = 3'd5;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr, r_trig_ptr;
  // r_fill counts words not yet handed over on the DATA channel, including
  // the one held in the output register; this keeps the RAM from ever being
  // overrun while the prefetch register is occupied.
  logic [AW:0]           r_fill;
  logic [PW-1:0]         r_post_cnt;
  logic [DELAY_BITS-1:0] r_delay;
  logic                  r_triggered, r_overflow, r_data_valid;

  logic [PW-1:0] w_post_prod, w_post_shr, w_post_len, w_post_next;
  logic [AW:0]   w_ram_cnt;
  logic w_ctrl_acc, w_status_acc, w_drain, w_xfer, w_load, w_full;
  logic w_capture, w_push_stream, w_write, w_trig_evt;

  assign CONTROL_READY_O = (r_state == S_IDLE) || (r_state == S_STREAM);
  assign STATUS_VALID_O  = (r_state == S_DONE) || (r_state == S_STREAM);
  assign DATA_VALID_O    = r_data_valid;

  assign w_ctrl_acc   = CONTROL_VALID_I && CONTROL_READY_O;
  assign w_status_acc = STATUS_VALID_O && STATUS_READY_I;

  // Post-trigger length includes the trigger sample itself, so never below 1.
  assign w_post_prod = (PW'(r_delay) + PW'(1)) * PW'(DEPTH - 1);
  assign w_post_shr  = w_post_prod >> DELAY_BITS;
  assign w_post_len  = (w_post_shr == '0) ? PW'(1) : w_post_shr;
  assign w_post_next = r_post_cnt + PW'(1);

  assign w_full    = (r_fill == C_FULL);
  assign w_drain   = (r_state == S_READOUT) || (r_state == S_STREAM);
  assign w_ram_cnt = r_fill - {{AW{1'b0}}, r_data_valid};
  assign w_xfer    = r_data_valid && DATA_READY_I;
  // Prefetch the next RAM word whenever the output register is empty or
  // being consumed this cycle; gives full rate with a registered DATA_O.
  assign w_load    = w_drain && (w_ram_cnt != '0) && (!r_data_valid || DATA_READY_I);

  assign w_capture     = SAMPLE_VALID_I && ((r_state == S_FILL) || (r_state == S_POST));
  // When full, a push is still accepted if a word leaves in the same cycle.
  assign w_push_stream = (r_state == S_STREAM) && SAMPLE_VALID_I && !w_ctrl_acc &&
                         (!w_full || w_xfer);
  assign w_write       = w_capture || w_push_stream;
  assign w_trig_evt    = SAMPLE_VALID_I && TRIG_I &&
                         ((r_state == S_FILL) ||
                          ((r_state == S_STREAM) && !r_triggered && !w_ctrl_acc));

  always_ff @(posedge CLK_I) begin
    if (w_write) r_mem[r_wr_ptr] <= SAMPLE_I;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_trig_ptr   <= '0;
      r_fill       <= '0;
      r_post_cnt   <= '0;
      r_delay      <= '0;
      r_triggered  <= 1'b0;
      r_overflow   <= 1'b0;
      r_data_valid <= 1'b0;
      DATA_O       <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);

      if (w_load) begin
        DATA_O       <= r_mem[r_rd_ptr];
        r_data_valid <= 1'b1;
        r_rd_ptr     <= r_rd_ptr + AW'(1);
      end else if (w_xfer) begin
        r_data_valid <= 1'b0;
      end

      if (w_drain)
        r_fill <= r_fill + (AW+1)'(w_push_stream) - (AW+1)'(w_xfer);
      else if (w_capture && !w_full)
        r_fill <= r_fill + (AW+1)'(1);

      if (w_trig_evt) begin
        r_trig_ptr  <= r_wr_ptr;
        r_triggered <= 1'b1;
      end

      if ((r_state == S_STREAM) && SAMPLE_VALID_I && !w_ctrl_acc && !w_push_stream)
        r_overflow <= 1'b1;

      case (r_state)
        S_FILL: begin
          if (SAMPLE_VALID_I && TRIG_I) begin
            r_post_cnt <= PW'(1);
            r_state    <= (w_post_len == PW'(1)) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (SAMPLE_VALID_I) begin
            r_post_cnt <= w_post_next;
            if (w_post_next == w_post_len) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_status_acc) begin
            // Oldest word sits `fill` entries behind the write pointer.
            r_rd_ptr <= r_wr_ptr - r_fill[AW-1:0];
            r_state  <= S_READOUT;
          end
        end
        S_READOUT: begin
          if (w_xfer && (r_fill == (AW+1)'(1))) r_state <= S_IDLE;
        end
        default: ;
      endcase

      // Accepted control write (IDLE or STREAM) restarts the buffer.
      if (w_ctrl_acc) begin
        r_delay      <= CONTROL_DELAY_I;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_trig_ptr   <= '0;
        r_fill       <= '0;
        r_post_cnt   <= '0;
        r_triggered  <= 1'b0;
        r_overflow   <= 1'b0;
        r_data_valid <= 1'b0;
        r_state      <= CONTROL_MODE_I ? S_STREAM : S_FILL;
      end
    end
  end

`ifdef TRB_TRIG_TIMESTAMP_EN
  logic [31:0] r_cycle, r_trig_ts;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_cycle   <= '0;
      r_trig_ts <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_ctrl_acc)      r_trig_ts <= '0;
      else if (w_trig_evt) r_trig_ts <= r_cycle;
    end
  end

  assign STATUS_O = {r_trig_ts, r_overflow, r_triggered, r_fill, r_trig_ptr};
`else
  assign STATUS_O = {r_overflow, r_triggered, r_fill, r_trig_ptr};
`endif

endmodule
`default_nettype wire
